// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern and active-low hex glyph table.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the {g,f,e,d,c,b,a} active-low glyph for hex value n (index 0 is the rightmost entry).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake bundle for seg7_scan_driver: a producer offers a digit word, the driver accepts it when free.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load_valid;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic                      load_ready;

  modport master (output load_valid, output digits, input load_ready);
  modport slave  (input load_valid, input digits, output load_ready);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with frame-aligned double-buffered loads.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  seg7_scan_driver_if.slave     load_if,
  output logic [6:0]            seg7,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] DIGIT0_SEL = NUM_DIGITS'(1);

  logic [PW-1:0]         prescaler_q;
  logic [IW-1:0]         idx_q;
  logic [DW-1:0]         shadow_q;
  logic [DW-1:0]         active_q;
  logic                  pending_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg7_q;

  logic       lastCycle;
  logic       frameTick;
  logic       transfer;
  logic [3:0] curNibble;
  logic [6:0] curSeg;
  logic [6:0] litSeg;

  assign lastCycle  = (prescaler_q == PW'(CLK_DIV - 1));
  assign frameTick  = lastCycle && (idx_q == IW'(NUM_DIGITS - 1));
  assign transfer   = load_if.load_valid && !pending_q;
  assign curNibble  = active_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hexDecode (
    .nibble_i (curNibble),
    .seg_o    (curSeg)
  );

`ifdef SEG7_SCAN_LZB_EN
  // zeroFromHere[i] is set when digit i and every more significant digit of active_q are zero.
  logic [NUM_DIGITS-1:0] zeroFromHere;
  logic                  zeroRun;

  always_comb begin
    zeroFromHere = '0;
    zeroRun      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroRun         = zeroRun && (active_q[4*i +: 4] == 4'h0);
      zeroFromHere[i] = zeroRun;
    end
  end

  assign litSeg = ((idx_q != '0) && zeroFromHere[idx_q]) ? SEG_OFF : curSeg;
`else
  assign litSeg = curSeg;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      an_q        <= '1;
      seg7_q      <= SEG_OFF;
    end else begin
      prescaler_q <= lastCycle ? '0 : prescaler_q + 1'b1;
      if (lastCycle) begin
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      // A transfer can only happen with pending clear, so it never races the commit below.
      if (transfer) begin
        shadow_q  <= load_if.digits;
        pending_q <= 1'b1;
      end else if (frameTick && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end

      if (prescaler_q < PW'(BLANK_CYCLES)) begin
        an_q   <= '1;
        seg7_q <= SEG_OFF;
      end else begin
        an_q   <= ~(DIGIT0_SEL << idx_q);
        seg7_q <= litSeg;
      end
    end
  end

  assign load_if.load_ready = !pending_q;
  assign seg7               = seg7_q;
  assign an                 = an_q;
  assign frame_tick         = frameTick;

endmodule
